// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, read-only word memory, next-PC
// selection, and RUN/HALT/FAULT tracking with a retired-instruction counter.
module instr_fetch #(
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] HALT_WORD = 32'h0000000C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] instruction,
   output logic        valid,
   output logic        halted,
   output logic        fault,
   output logic [31:0] retire_count
);

   localparam int          AW        = $clog2(MEM_DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

   typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

   // Contents are loaded externally before reset is released.
   logic [31:0] mem [MEM_DEPTH];

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_count;
   logic        r_valid;
   logic        r_halted;
   logic        r_fault;

   logic [31:0] w_word;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_next_pc;
   logic        w_bad_pc;
   logic        w_advance;

   assign w_word     = mem[r_pc[AW+1:2]];
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
   assign w_bad_pc   = (r_pc[1:0] != 2'b00) || (r_pc >= MEM_BYTES);
   assign w_advance  = (r_state == S_RUN) && !stall;

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (jr)
         w_next_pc = jr_addr;
      else if (jump)
         w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
      else if (branch_taken)
         w_next_pc = w_pc_plus4 + w_br_off;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_RUN;
         r_pc     <= RESET_PC;
         r_count  <= 32'd0;
         r_valid  <= 1'b1;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
      end else if (w_advance) begin
         // An illegal address is never retired and wins over the halt check.
         if (w_bad_pc) begin
            r_state <= S_FAULT;
            r_valid <= 1'b0;
            r_fault <= 1'b1;
         end else begin
            r_count <= r_count + 32'd1;
            if (w_word == HALT_WORD) begin
               r_state  <= S_HALT;
               r_valid  <= 1'b0;
               r_halted <= 1'b1;
            end else begin
               r_pc <= w_next_pc;
            end
         end
      end
   end

   assign pc_out       = r_pc;
   assign pc_plus4     = w_pc_plus4;
   assign instruction  = r_valid ? w_word : 32'h0;
   assign valid        = r_valid;
   assign halted       = r_halted;
   assign fault        = r_fault;
   assign retire_count = r_count;

endmodule
